// File: rtl/rtsnoc_rx_buffer_pkg.sv
// rtl/rtsnoc_rx_buffer_pkg.sv - bus-width derivation and ingress FSM encoding for the RTSNoC receive buffer
package rtsnoc_rx_buffer_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_ACK_WAIT = 1'b1
  } ingress_state_e;

  function automatic int noc_header_size(input int soc_size_x, input int soc_size_y);
    return 2 * soc_size_x + 2 * soc_size_y + 6;
  endfunction

  function automatic int noc_bus_size(input int data_width, input int soc_size_x, input int soc_size_y);
    return data_width + noc_header_size(soc_size_x, soc_size_y);
  endfunction

endpackage

// File: rtl/rtsnoc_rx_buffer_if.sv
// rtl/rtsnoc_rx_buffer_if.sv - router-side ingress and consumer-side egress signals of the receive buffer
interface rtsnoc_rx_buffer_if #(
  parameter int BUS_W = 42,
  parameter int CNT_W = 4
);
  logic [BUS_W-1:0] noc_dout_i;
  logic             noc_nd_i;
  logic             noc_rd_o;
  logic [BUS_W-1:0] rx_dout_o;
  logic             rx_nd_o;
  logic             rx_rd_i;
  logic [CNT_W-1:0] rx_count_o;
  logic             rx_full_o;
  logic             rx_int_o;

  modport master (
    output noc_dout_i, noc_nd_i, rx_rd_i,
    input  noc_rd_o, rx_dout_o, rx_nd_o, rx_count_o, rx_full_o, rx_int_o
  );

  modport slave (
    input  noc_dout_i, noc_nd_i, rx_rd_i,
    output noc_rd_o, rx_dout_o, rx_nd_o, rx_count_o, rx_full_o, rx_int_o
  );
endinterface

// File: rtl/rtsnoc_sync_fifo.sv
// rtl/rtsnoc_sync_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module rtsnoc_sync_fifo #(
  parameter int WIDTH      = 42,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_do_push;
  logic                  w_do_pop;

  // Full is judged on the count before any same-cycle pop, so a push into a full FIFO is refused.
  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/rtsnoc_rx_buffer.sv
// rtl/rtsnoc_rx_buffer.sv - elastic buffer draining an RTSNoC router local port into a FIFO re-presented as a router port
module rtsnoc_rx_buffer
  import rtsnoc_rx_buffer_pkg::*;
#(
  parameter int SOC_SIZE_X     = 1,
  parameter int SOC_SIZE_Y     = 1,
  parameter int NOC_DATA_WIDTH = 32,
  parameter int DEPTH_LOG2     = 3,
  parameter int WATERMARK      = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rtsnoc_rx_buffer_if.slave  bus
);

  localparam int BUS_W = noc_bus_size(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y);
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] WM = CNT_W'(WATERMARK);

  ingress_state_e   r_state;
  ingress_state_e   w_state_next;
  logic             w_noc_rd;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [BUS_W-1:0] w_head;
  logic             r_int;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ACK_WAIT absorbs the router's one-cycle lag in dropping nd after our rd pulse.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.noc_nd_i && !w_full) begin
          w_state_next = ST_ACK_WAIT;
        end
      end
      ST_ACK_WAIT: w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_noc_rd = 1'b0;
    if (r_state == ST_IDLE && bus.noc_nd_i && !w_full) begin
      w_noc_rd = 1'b1;
    end
  end

  rtsnoc_sync_fifo #(
    .WIDTH      (BUS_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_noc_rd),
    .i_data  (bus.noc_dout_i),
    .i_pop   (bus.rx_rd_i),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_int <= 1'b0;
    end else begin
      r_int <= (w_count >= WM);
    end
  end

  assign bus.noc_rd_o   = w_noc_rd;
  assign bus.rx_dout_o  = w_head;
  assign bus.rx_nd_o    = !w_empty;
  assign bus.rx_count_o = w_count;
  assign bus.rx_full_o  = w_full;
  assign bus.rx_int_o   = r_int;

endmodule

// File: tb/tb_rtsnoc_rx_buffer.sv
// tb/tb_rtsnoc_rx_buffer.sv - directed table and sequence bench for the RTSNoC receive buffer
module tb_rtsnoc_rx_buffer;

  localparam int BUS_W = 42;
  localparam int CNT_W = 4;

  typedef struct {
    logic             rst;
    logic             nd;
    logic [BUS_W-1:0] din;
    logic             rd;
    logic             e_noc_rd;
    logic             e_nd;
    logic [CNT_W-1:0] e_cnt;
    logic             e_full;
    logic             e_int;
    logic [BUS_W-1:0] e_dout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   sent, recv, total;
  logic w_rd_seen;

  rtsnoc_rx_buffer_if #(.BUS_W(BUS_W), .CNT_W(CNT_W)) bus ();

  rtsnoc_rx_buffer #(
    .SOC_SIZE_X     (1),
    .SOC_SIZE_Y     (1),
    .NOC_DATA_WIDTH (32),
    .DEPTH_LOG2     (3),
    .WATERMARK      (1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] flit(input int k);
    return {10'(k * 3 + 1), 32'hC0DE_0000 + 32'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Router model presents flit(sent) while it has flits left; consumer pops when pop_en.
  task automatic cycle(input logic pop_en);
    logic w_pop;
    bus.noc_nd_i   = (sent < total);
    bus.noc_dout_i = flit(sent);
    bus.rx_rd_i    = pop_en;
    #1;
    w_rd_seen = bus.noc_rd_o;
    w_pop = pop_en && bus.rx_nd_o;
    if (w_pop) begin
      chk("pop_order", 64'(bus.rx_dout_o), 64'(flit(recv)));
      recv++;
    end
    tick();
    if (w_rd_seen) sent++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.noc_nd_i = 1'b0;
    bus.rx_rd_i  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sent = 0;
    recv = 0;
  endtask

  vec_t vecs [12];

  initial begin
    int pulses, last_cyc, n;
    bus.noc_dout_i = '0;
    bus.noc_nd_i   = 1'b0;
    bus.rx_rd_i    = 1'b0;
    vecs[0]  = '{1'b1, 1'b0, 42'h0,           1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 42'h0};
    vecs[1]  = '{1'b0, 1'b1, 42'h2_AAAA_5555, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 42'h2_AAAA_5555};
    vecs[2]  = '{1'b0, 1'b0, 42'h2_AAAA_5555, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 42'h2_AAAA_5555};
    vecs[3]  = '{1'b0, 1'b0, 42'h0,           1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 42'h0};
    vecs[4]  = '{1'b0, 1'b0, 42'h0,           1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 42'h0};
    vecs[5]  = '{1'b0, 1'b0, 42'h0,           1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 42'h0};
    vecs[6]  = '{1'b0, 1'b1, 42'h1_1234_5678, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 42'h1_1234_5678};
    vecs[7]  = '{1'b0, 1'b1, 42'h1_1234_5678, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 42'h1_1234_5678};
    vecs[8]  = '{1'b0, 1'b1, 42'h3_CAFE_F00D, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 42'h3_CAFE_F00D};
    vecs[9]  = '{1'b0, 1'b0, 42'h0,           1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 42'h3_CAFE_F00D};
    vecs[10] = '{1'b0, 1'b0, 42'h0,           1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 42'h0};
    vecs[11] = '{1'b0, 1'b0, 42'h0,           1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 42'h0};

    tick();
    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst;
      bus.noc_nd_i   = vecs[i].nd;
      bus.noc_dout_i = vecs[i].din;
      bus.rx_rd_i    = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_noc_rd", i), 64'(bus.noc_rd_o), 64'(vecs[i].e_noc_rd));
      tick();
      chk($sformatf("v%0d_nd", i), 64'(bus.rx_nd_o), 64'(vecs[i].e_nd));
      chk($sformatf("v%0d_count", i), 64'(bus.rx_count_o), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d_full", i), 64'(bus.rx_full_o), 64'(vecs[i].e_full));
      chk($sformatf("v%0d_int", i), 64'(bus.rx_int_o), 64'(vecs[i].e_int));
      if (vecs[i].e_nd) chk($sformatf("v%0d_dout", i), 64'(bus.rx_dout_o), 64'(vecs[i].e_dout));
    end

    // Ten-flit burst into an eight-deep FIFO with the consumer idle.
    do_reset();
    total = 10;
    pulses = 0;
    last_cyc = 0;
    for (int c = 0; c < 24; c++) begin
      cycle(1'b0);
      if (w_rd_seen) begin
        if (pulses > 0) chk("rd_spacing", 64'(c - last_cyc), 64'd2);
        pulses++;
        last_cyc = c;
      end
    end
    chk("burst_pulses", 64'(pulses), 64'd8);
    chk("burst_count", 64'(bus.rx_count_o), 64'd8);
    chk("burst_full", 64'(bus.rx_full_o), 64'd1);
    chk("burst_int", 64'(bus.rx_int_o), 64'd1);

    cycle(1'b1);
    chk("full_pop_no_rd", 64'(w_rd_seen), 64'd0);
    chk("full_pop_count", 64'(bus.rx_count_o), 64'd7);
    chk("full_pop_full", 64'(bus.rx_full_o), 64'd0);
    cycle(1'b0);
    chk("after_pop_rd", 64'(w_rd_seen), 64'd1);
    chk("after_pop_count", 64'(bus.rx_count_o), 64'd8);

    n = 0;
    while (recv < 10 && n < 60) begin
      cycle(1'b1);
      n++;
    end
    chk("burst_drained", 64'(recv), 64'd10);
    chk("burst_empty_count", 64'(bus.rx_count_o), 64'd0);

    // Twenty flits with random consumer stalls, wrapping the pointers twice.
    do_reset();
    total = 20;
    n = 0;
    while (recv < 20 && n < 400) begin
      cycle(1'($urandom_range(0, 1)));
      n++;
    end
    chk("stall_received", 64'(recv), 64'd20);
    chk("stall_sent", 64'(sent), 64'd20);
    cycle(1'b0);
    chk("stall_count", 64'(bus.rx_count_o), 64'd0);

    // Reset mid-operation with five flits buffered.
    do_reset();
    total = 5;
    n = 0;
    while (sent < 5 && n < 40) begin
      cycle(1'b0);
      n++;
    end
    chk("pre_rst_count", 64'(bus.rx_count_o), 64'd5);
    rst = 1'b1;
    bus.noc_nd_i = 1'b0;
    bus.rx_rd_i  = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_count", 64'(bus.rx_count_o), 64'd0);
    chk("rst_nd", 64'(bus.rx_nd_o), 64'd0);
    chk("rst_int", 64'(bus.rx_int_o), 64'd0);
    chk("rst_full", 64'(bus.rx_full_o), 64'd0);
    bus.noc_nd_i = 1'b1;
    #1;
    chk("rst_fsm_idle", 64'(bus.noc_rd_o), 64'd1);
    tick();
    bus.noc_nd_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
